// File: rtl/ccx_ic_qos_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : ccx_ic_qos_arb_if
// Description : Bundle of the two upstream requester channels (packed, slot i
//               belongs to requester i) and the single shared downstream
//               request/response channel of the QoS arbiter.
//               master : arbiter side (drives grants, responses, m_* request)
//               slave  : environment side (requesters + downstream target)
// Revision    : 1.0 - initial release
// ============================================================================
interface ccx_ic_qos_arb_if #(
    parameter int AW = 39,
    parameter int DW = 64
);
    // upstream request channels (bit 0 = data port, bit 1 = instruction port)
    logic [1:0]          rq_req;
    logic [1:0]          rq_gnt;
    logic [1:0]          rq_wen;
    logic [2*DW/8-1:0]   rq_strb;
    logic [2*AW-1:0]     rq_addr;
    logic [2*DW-1:0]     rq_wdata;
    // upstream response channels (error/rdata shared, qualified by rq_recv)
    logic [1:0]          rq_recv;
    logic [1:0]          rq_ack;
    logic                rq_error;
    logic [DW-1:0]       rq_rdata;
    // downstream request channel
    logic                m_req;
    logic                m_gnt;
    logic                m_wen;
    logic [DW/8-1:0]     m_strb;
    logic [AW-1:0]       m_addr;
    logic [DW-1:0]       m_wdata;
    // downstream response channel
    logic                m_recv;
    logic                m_ack;
    logic                m_error;
    logic [DW-1:0]       m_rdata;

    modport master (
        input  rq_req, rq_wen, rq_strb, rq_addr, rq_wdata, rq_ack,
        input  m_gnt, m_recv, m_error, m_rdata,
        output rq_gnt, rq_recv, rq_error, rq_rdata,
        output m_req, m_wen, m_strb, m_addr, m_wdata, m_ack
    );

    modport slave (
        output rq_req, rq_wen, rq_strb, rq_addr, rq_wdata, rq_ack,
        output m_gnt, m_recv, m_error, m_rdata,
        input  rq_gnt, rq_recv, rq_error, rq_rdata,
        input  m_req, m_wen, m_strb, m_addr, m_wdata, m_ack
    );
endinterface
`default_nettype wire

// File: rtl/ccx_ic_qos_arb.sv
`default_nettype none
// ============================================================================
// Module      : ccx_ic_qos_arb
// Description : Two-requester QoS arbiter onto one shared downstream port.
//               Requester 0 (data) has priority; requester 1 (instruction) is
//               forced through after STARVE_MAX back-to-back requester-0
//               grants. A 2-deep ID FIFO routes in-order responses back.
// Ports       : g_clk   - clock, all state on rising edge
//               g_reset - synchronous active-high reset
//               bus     - ccx_ic_qos_arb_if.master (rq_* upstream, m_* down)
// Revision    : 1.0 - initial release
// ============================================================================
module ccx_ic_qos_arb #(
    parameter int AW         = 39,
    parameter int DW         = 64,
    parameter int STARVE_MAX = 4
) (
    input  wire logic          g_clk,
    input  wire logic          g_reset,
    ccx_ic_qos_arb_if.master   bus
);
    localparam int c_SW = DW / 8;
    localparam int c_CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [c_CW-1:0] c_STARVE_MAX = c_CW'(STARVE_MAX);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_sel;
    logic            r_rst_d;
    logic [c_CW-1:0] r_starve;
    logic            r_fifo [0:1];
    logic            r_rd_ptr;
    logic            r_wr_ptr;
    logic [1:0]      r_count;

    logic            w_sel;
    logic            w_want;
    logic            w_mreq;
    logic            w_block;
    logic            w_empty;
    logic            w_full;
    logic            w_head;
    logic            w_push;
    logic            w_pop;
    logic            w_recv;
    logic            w_mack;

    // m_req is also held off the cycle after reset
    assign w_block = g_reset | r_rst_d;
    assign w_empty = (r_count == 2'd0);
    assign w_full  = (r_count == 2'd2);
    assign w_head  = r_fifo[r_rd_ptr];

    assign w_mack  = w_empty ? 1'b1 : (w_head ? bus.rq_ack[1] : bus.rq_ack[0]);
    assign w_pop   = bus.m_recv & w_mack & ~w_empty;
    assign w_recv  = bus.m_recv & ~w_empty & ~g_reset;
    assign w_push  = w_mreq & bus.m_gnt;

    // selection / lock FSM, next state and request
    always_comb begin
        w_sel       = 1'b0;
        w_want      = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            ST_LOCK: begin
                // a stalled request is held verbatim until the target takes it
                w_sel  = r_sel;
                w_want = 1'b1;
            end
            default: begin
                if (bus.rq_req[1] && (r_starve == c_STARVE_MAX)) begin
                    w_sel  = 1'b1;
                    w_want = 1'b1;
                end else if (bus.rq_req[0]) begin
                    w_sel  = 1'b0;
                    w_want = 1'b1;
                end else if (bus.rq_req[1]) begin
                    w_sel  = 1'b1;
                    w_want = 1'b1;
                end
            end
        endcase
        // a full FIFO may still accept when a response retires this cycle
        w_mreq = w_want & ~w_block & (~w_full | w_pop);
        if (w_mreq) begin
            w_state_nxt = bus.m_gnt ? ST_IDLE : ST_LOCK;
        end
    end

    always_ff @(posedge g_clk) begin
        r_rst_d <= g_reset;
        if (g_reset) begin
            r_state  <= ST_IDLE;
            r_sel    <= 1'b0;
            r_starve <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_mreq) begin
                r_sel <= w_sel;
            end
            if (!bus.rq_req[1]) begin
                r_starve <= '0;
            end else if (w_push) begin
                if (w_sel) begin
                    r_starve <= '0;
                end else if (r_starve != c_STARVE_MAX) begin
                    r_starve <= r_starve + c_CW'(1);
                end
            end
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ID storage needs no reset: occupancy is tracked by r_count
    always_ff @(posedge g_clk) begin
        if (!g_reset && w_push) begin
            r_fifo[r_wr_ptr] <= w_sel;
        end
    end

    assign bus.m_req    = w_mreq;
    assign bus.m_wen    = w_sel ? bus.rq_wen[1] : bus.rq_wen[0];
    assign bus.m_strb   = w_sel ? bus.rq_strb[2*c_SW-1:c_SW] : bus.rq_strb[c_SW-1:0];
    assign bus.m_addr   = w_sel ? bus.rq_addr[2*AW-1:AW] : bus.rq_addr[AW-1:0];
    assign bus.m_wdata  = w_sel ? bus.rq_wdata[2*DW-1:DW] : bus.rq_wdata[DW-1:0];
    assign bus.rq_gnt   = {w_sel & w_push, ~w_sel & w_push};
    assign bus.rq_recv  = {w_head & w_recv, ~w_head & w_recv};
    assign bus.m_ack    = w_mack;
    assign bus.rq_error = bus.m_error;
    assign bus.rq_rdata = bus.m_rdata;
endmodule
`default_nettype wire

// File: tb/tb_ccx_ic_qos_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_ccx_ic_qos_arb
// Description : Scoreboard bench for ccx_ic_qos_arb. A driver applies directed
//               and random stimulus and a transaction-level model predicts
//               acceptances, responses and per-cycle m_req/m_ack; a monitor
//               compares what the DUT presents against those predictions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ccx_ic_qos_arb;
    localparam int AW = 39;
    localparam int DW = 64;
    localparam int SM = 4;
    localparam int SW = DW / 8;

    logic g_clk = 1'b0;
    logic g_reset;
    always #5 g_clk = ~g_clk;

    ccx_ic_qos_arb_if #(.AW(AW), .DW(DW)) bus();

    ccx_ic_qos_arb #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .bus     (bus.master)
    );

    typedef struct {
        int            cyc;
        bit            id;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        logic          wen;
    } acc_t;
    typedef struct {
        int            cyc;
        bit            id;
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;
    typedef struct {
        int   cyc;
        logic mreq;
        logic mack;
        logic chk_ack;
    } cyc_t;

    acc_t acc_q[$];
    rsp_t rsp_q[$];
    cyc_t cyc_q[$];

    // reference model state: outstanding requester ids in issue order
    int   mq[$];
    int   starve;
    bit   locked;
    bit   lock_id;
    bit   prev_rst;
    int   cyc;
    int   errors;
    int   checks;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // one clock of stimulus plus its predicted outcome
    task automatic step(input bit rst, input bit [1:0] req, input bit gnt,
                        input bit recv, input bit [1:0] ack);
        logic [127:0] t;
        bit   want, id, pop, mreq, mack, acc, blk;
        acc_t a;
        rsp_t r;
        @(posedge g_clk);
        #1;
        t = {$urandom, $urandom, $urandom, $urandom};
        bus.rq_addr  = t[2*AW-1:0];
        t = {$urandom, $urandom, $urandom, $urandom};
        bus.rq_wdata = t;
        t = {96'd0, $urandom};
        bus.rq_strb  = t[2*SW-1:0];
        bus.rq_wen   = 2'($urandom);
        t = {64'd0, $urandom, $urandom};
        bus.m_rdata  = t[DW-1:0];
        bus.m_error  = 1'($urandom);
        g_reset      = rst;
        bus.rq_req   = req;
        bus.m_gnt    = gnt;
        bus.m_recv   = recv;
        bus.rq_ack   = ack;
        cyc++;

        blk  = rst || prev_rst;
        want = 1'b1;
        id   = 1'b0;
        if (locked)                     id = lock_id;
        else if (req[1] && starve == SM) id = 1'b1;
        else if (req[0])                id = 1'b0;
        else if (req[1])                id = 1'b1;
        else                            want = 1'b0;
        mack = (mq.size() == 0) ? 1'b1 : ack[mq[0]];
        pop  = !rst && recv && mq.size() > 0 && ack[mq[0]];
        mreq = !blk && want && (mq.size() < 2 || pop);
        acc  = mreq && gnt;

        cyc_q.push_back('{cyc, mreq, mack, recv && !rst});
        if (acc) begin
            a.cyc   = cyc;
            a.id    = id;
            a.addr  = id ? bus.rq_addr[2*AW-1:AW]   : bus.rq_addr[AW-1:0];
            a.wdata = id ? bus.rq_wdata[2*DW-1:DW]  : bus.rq_wdata[DW-1:0];
            a.strb  = id ? bus.rq_strb[2*SW-1:SW]   : bus.rq_strb[SW-1:0];
            a.wen   = bus.rq_wen[id];
            acc_q.push_back(a);
        end
        if (!rst && recv && mq.size() > 0) begin
            r.cyc   = cyc;
            r.id    = mq[0][0];
            r.rdata = bus.m_rdata;
            r.err   = bus.m_error;
            rsp_q.push_back(r);
        end

        if (rst) begin
            mq.delete();
            starve = 0;
            locked = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(int'(id));
            if (!req[1])             starve = 0;
            else if (acc && id)      starve = 0;
            else if (acc && starve < SM) starve++;
            if (mreq && !gnt) begin
                locked  = 1'b1;
                lock_id = id;
            end else if (acc) begin
                locked = 1'b0;
            end
        end
        prev_rst = rst;
    endtask

    // monitor: compares whatever the DUT presents against the scoreboard
    initial begin
        cyc_t e;
        acc_t a;
        rsp_t r;
        forever begin
            @(negedge g_clk);
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                chk("m_req", bus.m_req, e.mreq);
                if (e.chk_ack) chk("m_ack", bus.m_ack, e.mack);
            end
            if (bus.m_req && bus.m_gnt) begin
                if (acc_q.size() == 0 || acc_q[0].cyc != cyc) begin
                    chk("acc_unexpected", 1, 0);
                end else begin
                    a = acc_q.pop_front();
                    chk("rq_gnt",  bus.rq_gnt, a.id ? 2'b10 : 2'b01);
                    chk("m_addr",  bus.m_addr, a.addr);
                    chk("m_wdata", bus.m_wdata, a.wdata);
                    chk("m_strb",  bus.m_strb, a.strb);
                    chk("m_wen",   bus.m_wen, a.wen);
                end
            end else begin
                chk("rq_gnt_idle", bus.rq_gnt, 2'b00);
            end
            while (acc_q.size() > 0 && acc_q[0].cyc <= cyc) begin
                chk("acc_missed", 0, 1);
                void'(acc_q.pop_front());
            end
            if (bus.rq_recv != 2'b00) begin
                if (rsp_q.size() == 0 || rsp_q[0].cyc != cyc) begin
                    chk("rsp_unexpected", bus.rq_recv, 0);
                end else begin
                    r = rsp_q.pop_front();
                    chk("rq_recv",  bus.rq_recv, r.id ? 2'b10 : 2'b01);
                    chk("rq_rdata", bus.rq_rdata, r.rdata);
                    chk("rq_error", bus.rq_error, r.err);
                end
            end
            while (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc) begin
                chk("rsp_missed", 0, 1);
                void'(rsp_q.pop_front());
            end
        end
    end

    initial begin
        g_reset = 1'b1;
        bus.rq_req = '0; bus.rq_wen = '0; bus.rq_strb = '0; bus.rq_addr = '0;
        bus.rq_wdata = '0; bus.rq_ack = '0; bus.m_gnt = 1'b0; bus.m_recv = 1'b0;
        bus.m_error = 1'b0; bus.m_rdata = '0;
        starve = 0; locked = 1'b0; lock_id = 1'b0; prev_rst = 1'b0;
        cyc = 0; errors = 0; checks = 0;

        step(1, 2'b11, 1, 1, 2'b11);
        @(negedge g_clk);
        chk("reset_m_req",   bus.m_req, 1'b0);
        chk("reset_rq_gnt",  bus.rq_gnt, 2'b00);
        chk("reset_rq_recv", bus.rq_recv, 2'b00);
        step(0, 2'b11, 1, 0, 2'b00);
        @(negedge g_clk);
        chk("post_reset_m_req", bus.m_req, 1'b0);
        step(0, 2'b00, 0, 0, 2'b00);

        // empty FIFO with a stray response: acknowledged, not routed
        step(0, 2'b00, 0, 1, 2'b00);
        @(negedge g_clk);
        chk("stray_m_ack",   bus.m_ack, 1'b1);
        chk("stray_rq_recv", bus.rq_recv, 2'b00);

        // both requesting, target always ready: 0,0,0,0,1 repeating
        for (int k = 0; k < 10; k++) begin
            step(0, 2'b11, 1, 1, 2'b11);
            @(negedge g_clk);
            chk("starve_seq", bus.rq_gnt, (k % 5 == 4) ? 2'b10 : 2'b01);
        end
        step(0, 2'b00, 0, 1, 2'b11);
        step(0, 2'b00, 0, 0, 2'b00);

        // stalled requester 0 stays locked while requester 1 arrives
        step(0, 2'b01, 0, 0, 2'b00);
        step(0, 2'b11, 0, 0, 2'b00);
        step(0, 2'b11, 0, 0, 2'b00);
        step(0, 2'b11, 1, 0, 2'b00);
        @(negedge g_clk);
        chk("lock_gnt", bus.rq_gnt, 2'b01);
        step(0, 2'b00, 0, 1, 2'b11);

        // ids 1 then 0 outstanding, third request blocked, in-order return
        step(0, 2'b10, 1, 0, 2'b00);
        step(0, 2'b01, 1, 0, 2'b00);
        step(0, 2'b11, 1, 0, 2'b00);
        @(negedge g_clk);
        chk("full_m_req", bus.m_req, 1'b0);
        step(0, 2'b00, 0, 1, 2'b11);
        @(negedge g_clk);
        chk("order_first", bus.rq_recv, 2'b10);
        // refill to full, then pop and push in the same cycle
        step(0, 2'b10, 1, 0, 2'b00);
        step(0, 2'b01, 1, 1, 2'b11);
        @(negedge g_clk);
        chk("full_pop_push", bus.rq_gnt, 2'b01);
        step(0, 2'b01, 1, 0, 2'b00);
        @(negedge g_clk);
        chk("still_full", bus.m_req, 1'b0);
        step(0, 2'b00, 0, 1, 2'b11);
        step(0, 2'b00, 0, 1, 2'b11);

        // two outstanding with starve count 3, then reset
        step(0, 2'b11, 1, 0, 2'b00);
        step(0, 2'b11, 1, 0, 2'b00);
        step(0, 2'b11, 1, 1, 2'b11);
        step(1, 2'b11, 1, 1, 2'b11);
        step(0, 2'b11, 1, 1, 2'b11);
        @(negedge g_clk);
        chk("rst_flush_m_req",   bus.m_req, 1'b0);
        chk("rst_flush_rq_recv", bus.rq_recv, 2'b00);
        step(0, 2'b11, 1, 0, 2'b00);
        @(negedge g_clk);
        chk("rst_starve_clear", bus.rq_gnt, 2'b01);
        step(0, 2'b00, 0, 1, 2'b11);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) == 0), 2'($urandom), ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 2) != 0), (($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom)));
        end
        for (int n = 0; n < 4; n++) step(0, 2'b00, 0, 1, 2'b11);
        @(negedge g_clk);
        #1;
        chk("acc_q_drained", acc_q.size(), 0);
        chk("rsp_q_drained", rsp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
